// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// Result encoding is {gt, eq, lt}, one-hot when a compare is performed.
package comparator_pkg;

   localparam int SLICE_W = 4;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_result_t;

   localparam cmp_result_t CMP_NONE = 3'b000;
   localparam cmp_result_t CMP_GT   = 3'b100;
   localparam cmp_result_t CMP_EQ   = 3'b010;
   localparam cmp_result_t CMP_LT   = 3'b001;

endpackage

// File: rtl/comparator_slice.sv
// Combinational 4-bit magnitude compare with 7485-style cascade inputs.
// A tie on this slice defers to the result of the less-significant slices.
module comparator_slice
   import comparator_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               gt_in,
   input  logic               eq_in,
   input  logic               lt_in,
   output logic               gt_out,
   output logic               eq_out,
   output logic               lt_out
);

   always_comb begin
      gt_out = 1'b0;
      eq_out = 1'b0;
      lt_out = 1'b0;
      if (a > b) begin
         gt_out = 1'b1;
      end else if (a < b) begin
         lt_out = 1'b1;
      end else begin
         gt_out = gt_in;
         eq_out = eq_in;
         lt_out = lt_in;
      end
   end

endmodule

// File: rtl/comparator.sv
// Registered greater/equal/less flags for two WIDTH-bit operands, unsigned
// or two's-complement per cycle; one cycle of latency, flags zero when idle.
module comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             signed_cmp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             greater,
   output logic             equal,
   output logic             less
);

   localparam int N_SLICE = WIDTH / SLICE_W;

   logic [N_SLICE:0] casc_gt;
   logic [N_SLICE:0] casc_eq;
   logic [N_SLICE:0] casc_lt;

   assign casc_gt[0] = CMP_EQ.gt;
   assign casc_eq[0] = CMP_EQ.eq;
   assign casc_lt[0] = CMP_EQ.lt;

   for (genvar i = 0; i < N_SLICE; i++) begin : g_slice
      comparator_slice u_slice (
         .a      (a[i*SLICE_W +: SLICE_W]),
         .b      (b[i*SLICE_W +: SLICE_W]),
         .gt_in  (casc_gt[i]),
         .eq_in  (casc_eq[i]),
         .lt_in  (casc_lt[i]),
         .gt_out (casc_gt[i+1]),
         .eq_out (casc_eq[i+1]),
         .lt_out (casc_lt[i+1])
      );
   end

   cmp_result_t cmp_res;
   cmp_result_t res_q;

   // With differing sign bits the non-negative operand wins; otherwise the
   // unsigned chain result already holds for two's complement.
   always_comb begin
      cmp_res = '{gt: casc_gt[N_SLICE], eq: casc_eq[N_SLICE], lt: casc_lt[N_SLICE]};
      if (signed_cmp && (a[WIDTH-1] != b[WIDTH-1])) begin
         cmp_res = a[WIDTH-1] ? CMP_LT : CMP_GT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= CMP_NONE;
      end else if (!en) begin
         res_q <= CMP_NONE;
      end else begin
         res_q <= cmp_res;
      end
   end

   assign greater = res_q.gt;
   assign equal   = res_q.eq;
   assign less    = res_q.lt;

endmodule

// File: tb/tb_comparator.sv
// Bench for comparator: directed vectors on a 4-bit instance, randomized
// sweep on an 8-bit instance against an integer-arithmetic reference.
module tb_comparator;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, en4, sc4;
   logic [3:0] a4, b4;
   logic       gt4, eq4, lt4;

   logic       rst8, en8, sc8;
   logic [7:0] a8, b8;
   logic       gt8, eq8, lt8;

   comparator #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .en(en4), .signed_cmp(sc4),
      .a(a4), .b(b4), .greater(gt4), .equal(eq4), .less(lt4)
   );

   comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .en(en8), .signed_cmp(sc8),
      .a(a8), .b(b8), .greater(gt8), .equal(eq8), .less(lt8)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got gel=%b expected gel=%b", tag, got, exp);
   endtask

   // Reference: interpret operands as integers, then compare numerically.
   function automatic logic [2:0] ref_cmp(input int w, input bit en, input bit sc,
                                          input int ua, input int ub);
      int va, vb;
      if (!en) return 3'b000;
      va = (sc && ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      vb = (sc && ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      if (va > vb) return 3'b100;
      if (va == vb) return 3'b010;
      return 3'b001;
   endfunction

   task automatic step4(input string tag, input bit r, input bit e, input bit s,
                        input logic [3:0] va, input logic [3:0] vb);
      logic [2:0] exp;
      @(negedge clk);
      rst4 = r; en4 = e; sc4 = s; a4 = va; b4 = vb;
      exp = r ? 3'b000 : ref_cmp(4, e, s, int'(va), int'(vb));
      @(posedge clk);
      #1;
      chk(tag, {gt4, eq4, lt4}, exp);
   endtask

   logic [3:0] ua_vec [8] = '{4'b1001, 4'b1100, 4'b0100, 4'b0101,
                              4'b0010, 4'b1001, 4'b0110, 4'b0000};
   logic [3:0] ub_vec [8] = '{4'b0101, 4'b1100, 4'b1001, 4'b0001,
                              4'b0111, 4'b0011, 4'b1000, 4'b1111};
   logic [2:0] ue_vec [8] = '{3'b100, 3'b010, 3'b001, 3'b100,
                              3'b001, 3'b100, 3'b001, 3'b001};

   initial begin
      rst4 = 1'b1; en4 = 1'b0; sc4 = 1'b0; a4 = '0; b4 = '0;
      rst8 = 1'b1; en8 = 1'b0; sc8 = 1'b0; a8 = '0; b8 = '0;

      // reset holds outputs low even with a live compare pending
      step4("rst_hold0", 1, 1, 0, 4'b1001, 4'b0101);
      step4("rst_hold1", 1, 1, 0, 4'b1001, 4'b0101);
      step4("rst_release", 0, 1, 0, 4'b1001, 4'b0101);
      chk("rst_release_gt", {gt4, eq4, lt4}, 3'b100);

      for (int i = 0; i < 8; i++) begin
         step4($sformatf("uns%0d", i), 0, 1, 0, ua_vec[i], ub_vec[i]);
         chk($sformatf("uns%0d_const", i), {gt4, eq4, lt4}, ue_vec[i]);
      end

      step4("en0_eq", 0, 0, 0, 4'b0011, 4'b0011);
      chk("en0_eq_const", {gt4, eq4, lt4}, 3'b000);
      step4("en0_gt", 0, 0, 0, 4'b1111, 4'b0000);
      step4("en1_lt", 0, 1, 0, 4'b0000, 4'b1111);
      chk("en1_lt_const", {gt4, eq4, lt4}, 3'b001);

      step4("sgn_m7_p5", 0, 1, 1, 4'b1001, 4'b0101);
      chk("sgn_m7_p5_const", {gt4, eq4, lt4}, 3'b001);
      step4("sgn_m1_0", 0, 1, 1, 4'b1111, 4'b0000);
      chk("sgn_m1_0_const", {gt4, eq4, lt4}, 3'b001);
      step4("sgn_6_m8", 0, 1, 1, 4'b0110, 4'b1000);
      chk("sgn_6_m8_const", {gt4, eq4, lt4}, 3'b100);
      step4("sgn_m8_m8", 0, 1, 1, 4'b1000, 4'b1000);
      chk("sgn_m8_m8_const", {gt4, eq4, lt4}, 3'b010);

      step4("mid_pre0", 0, 1, 0, 4'b0111, 4'b0011);
      step4("mid_rst", 1, 1, 0, 4'b0001, 4'b0010);
      step4("mid_post0", 0, 1, 0, 4'b0001, 4'b0010);
      step4("mid_post1", 0, 1, 1, 4'b1110, 4'b1101);

      // 8-bit randomized sweep: reference computed from inputs of the same edge
      @(negedge clk);
      rst8 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         logic [2:0] exp8;
         @(negedge clk);
         en8 = 1'($urandom_range(0, 3) != 0);
         sc8 = 1'($urandom);
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         if ((i % 50) == 0) b8 = a8;
         exp8 = ref_cmp(8, en8, sc8, int'(a8), int'(b8));
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d", i), {gt8, eq8, lt8}, exp8);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
- Registered magnitude comparator: compares two WIDTH-bit operands a and b and drives one-hot greater/equal/less flags one clock after sampling.
- A low enable forces all flags to zero.
- Used as a leaf compare unit in datapath control logic, e.g. threshold checks and sort/select decisions.
- Supports unsigned (default) and two's-complement signed comparison, selected per cycle.

Parameters:
- WIDTH, 4, operand width in bits. Legal values are multiples of 4, minimum 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  compare enable, sampled on the clock edge.
- signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned compare.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- greater  output  1  registered; 1 when A > B.
- equal  output  1  registered; 1 when A == B.
- less  output  1  registered; 1 when A < B.

Behaviour:
- All three outputs come directly from flops. Latency is 1 cycle: inputs sampled at edge N appear after edge N.
- Reset: if rst=1 at an edge, greater, equal and less all become 0. Reset takes priority over en and operands. Reset mid-stream discards the pending result, and the first valid result follows the first edge with rst=0 and en=1.
- en=0 at an edge (rst=0): all outputs become 0 at that edge, regardless of a and b.
- en=1 at an edge (rst=0): exactly one of greater, equal, less becomes 1. Outputs are strictly one-hot whenever en was 1, and never have two bits set.
- Unsigned mode (signed_cmp=0): operands are treated as 0..2^WIDTH-1.
- Signed mode (signed_cmp=1): operands are treated as two's complement.
  - If the MSBs differ, the operand with MSB=0 is greater.
  - Otherwise the result equals the unsigned compare of the full words.
- Equal is independent of signed_cmp.
- Operands are compared purely combinationally in the cycle they are sampled. No history is kept: back-to-back operand changes every cycle produce a result every cycle.
- No X-propagation requirements beyond reset. After reset all outputs are known 0.

Decomposition:
- Shared package comparator_pkg holds:
  - localparam SLICE_W = 4.
  - typedef cmp_result_t: packed struct {gt, eq, lt}.
  - constants CMP_NONE = 3'b000, CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001.
- Sub-module comparator_slice: a combinational 4-bit magnitude comparator with cascade inputs gt_in/eq_in/lt_in and cascade outputs, in 7485 style.
  - WIDTH/4 slices are chained from LSB slice to MSB slice via a generate loop.
  - The LSB slice's cascade input is tied to CMP_EQ.
- Signed correction is applied in comparator by inspecting the operand MSBs ahead of the output flops.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, a=4'b1001, b=4'b0101 -> outputs stay 000 (greater, equal, less). First edge after rst drops -> greater=1, equal=0, less=0.
- Unsigned directed sequence, en=1, signed_cmp=0, one vector per cycle; each result checked one cycle later:
  - 1001/0101 -> G
  - 1100/1100 -> E
  - 0100/1001 -> L
  - 0101/0001 -> G
  - 0010/0111 -> L
  - 1001/0011 -> G
  - 0110/1000 -> L
  - 0000/1111 -> L
- Enable gating:
  - en=0 with 0011/0011 -> all 0 (no equal).
  - en=0 with 1111/0000 -> all 0.
  - Next cycle en=1 with 0000/1111 -> less=1.
- Signed mode, signed_cmp=1:
  - 1001 (-7) vs 0101 (+5) -> less=1.
  - 1111 (-1) vs 0000 -> less=1.
  - 0110 vs 1000 (-8) -> greater=1.
  - 1000/1000 -> equal=1.
- Reset mid-operation: en=1 streaming vectors, assert rst for one cycle -> outputs 000 on that edge. Stream resumes with correct one-cycle-latency results.
- Randomized sweep, WIDTH=8, 1000 cycles, random en/signed_cmp/a/b -> outputs match a reference model delayed one cycle. Outputs are one-hot whenever en was 1 and zero otherwise.
